// File: rtl/rename_map.sv
// Register-rename stage: maps architectural sources/destinations onto physical tags,
// pops free tags per allocating slot, and keeps a retirement map for flush recovery.
module rename_map #(
    parameter  int ARCH_REGS = 32,
    parameter  int NUM_PHYS  = 64,
    parameter  int MAX_IO    = 3,
    localparam int ARCH_BITS = $clog2(ARCH_REGS),
    localparam int PHYS_BITS = $clog2(NUM_PHYS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MAX_IO-1:0]              in_en,
    input  logic [MAX_IO-1:0]              in_has_dst,
    input  logic [MAX_IO*ARCH_BITS-1:0]    in_dst,
    input  logic [MAX_IO*ARCH_BITS-1:0]    in_src1,
    input  logic [MAX_IO*ARCH_BITS-1:0]    in_src2,
    input  logic [PHYS_BITS:0]             fl_len,
    output logic [MAX_IO-1:0]              fl_get_en,
    input  logic [MAX_IO*PHYS_BITS-1:0]    fl_gotten,
    output logic [MAX_IO-1:0]              fl_put_en,
    output logic [MAX_IO*PHYS_BITS-1:0]    fl_put,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [MAX_IO-1:0]              out_en,
    output logic [MAX_IO-1:0]              out_has_dst,
    output logic [MAX_IO*PHYS_BITS-1:0]    out_psrc1,
    output logic [MAX_IO*PHYS_BITS-1:0]    out_psrc2,
    output logic [MAX_IO*PHYS_BITS-1:0]    out_pdst,
    output logic [MAX_IO*PHYS_BITS-1:0]    out_old_pdst,
    input  logic [MAX_IO-1:0]              commit_en,
    input  logic [MAX_IO*ARCH_BITS-1:0]    commit_arch,
    input  logic [MAX_IO*PHYS_BITS-1:0]    commit_pdst,
    input  logic [MAX_IO*PHYS_BITS-1:0]    commit_old_pdst,
    input  logic                           flush
);

    typedef logic [PHYS_BITS-1:0] tag_t;

    tag_t spec_map    [ARCH_REGS];
    tag_t retire_map  [ARCH_REGS];
    tag_t spec_next   [ARCH_REGS];
    tag_t retire_next [ARCH_REGS];

    logic [MAX_IO-1:0]           alloc;
    logic [PHYS_BITS:0]          need;
    logic                        accept;
    logic [MAX_IO*PHYS_BITS-1:0] psrc1_n, psrc2_n, pdst_n, old_pdst_n;

    always_comb begin
        alloc = in_en & in_has_dst;
        need  = '0;
        for (int i = 0; i < MAX_IO; i++) begin
            need = need + (PHYS_BITS+1)'(alloc[i]);
        end
    end

    assign in_ready  = rst && !flush && (!out_valid || out_ready) && (need <= fl_len);
    assign accept    = in_valid && in_ready;
    assign fl_get_en = accept ? alloc : '0;

    // Each slot sees the newest older-slot producer of its register, else the speculative map.
    always_comb begin
        psrc1_n    = '0;
        psrc2_n    = '0;
        pdst_n     = '0;
        old_pdst_n = '0;
        for (int i = 0; i < MAX_IO; i++) begin
            psrc1_n[i*PHYS_BITS +: PHYS_BITS]    = spec_map[in_src1[i*ARCH_BITS +: ARCH_BITS]];
            psrc2_n[i*PHYS_BITS +: PHYS_BITS]    = spec_map[in_src2[i*ARCH_BITS +: ARCH_BITS]];
            old_pdst_n[i*PHYS_BITS +: PHYS_BITS] = spec_map[in_dst[i*ARCH_BITS +: ARCH_BITS]];
            pdst_n[i*PHYS_BITS +: PHYS_BITS]     = alloc[i] ? fl_gotten[i*PHYS_BITS +: PHYS_BITS] : '0;
            // NOTE: blocking assignments in an ascending loop make the highest matching slot win.
            for (int j = 0; j < i; j++) begin
                if (alloc[j]) begin
                    if (in_dst[j*ARCH_BITS +: ARCH_BITS] == in_src1[i*ARCH_BITS +: ARCH_BITS])
                        psrc1_n[i*PHYS_BITS +: PHYS_BITS] = fl_gotten[j*PHYS_BITS +: PHYS_BITS];
                    if (in_dst[j*ARCH_BITS +: ARCH_BITS] == in_src2[i*ARCH_BITS +: ARCH_BITS])
                        psrc2_n[i*PHYS_BITS +: PHYS_BITS] = fl_gotten[j*PHYS_BITS +: PHYS_BITS];
                    if (in_dst[j*ARCH_BITS +: ARCH_BITS] == in_dst[i*ARCH_BITS +: ARCH_BITS])
                        old_pdst_n[i*PHYS_BITS +: PHYS_BITS] = fl_gotten[j*PHYS_BITS +: PHYS_BITS];
                end
            end
        end
    end

    // Flush restores the retirement map including this cycle's commits.
    always_comb begin
        retire_next = retire_map;
        for (int i = 0; i < MAX_IO; i++) begin
            if (commit_en[i])
                retire_next[commit_arch[i*ARCH_BITS +: ARCH_BITS]] = commit_pdst[i*PHYS_BITS +: PHYS_BITS];
        end
        spec_next = spec_map;
        if (flush) begin
            spec_next = retire_next;
        end else if (accept) begin
            for (int i = 0; i < MAX_IO; i++) begin
                if (alloc[i])
                    spec_next[in_dst[i*ARCH_BITS +: ARCH_BITS]] = fl_gotten[i*PHYS_BITS +: PHYS_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: both maps are flop arrays, not RAM, because reset must load the identity mapping.
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_map[i]   <= tag_t'(i);
                retire_map[i] <= tag_t'(i);
            end
            out_valid    <= 1'b0;
            out_en       <= '0;
            out_has_dst  <= '0;
            out_psrc1    <= '0;
            out_psrc2    <= '0;
            out_pdst     <= '0;
            out_old_pdst <= '0;
            fl_put_en    <= '0;
            fl_put       <= '0;
        end else begin
            spec_map   <= spec_next;
            retire_map <= retire_next;
            fl_put_en  <= commit_en;
            fl_put     <= commit_old_pdst;
            if (accept) begin
                out_valid    <= 1'b1;
                out_en       <= in_en;
                out_has_dst  <= in_has_dst;
                out_psrc1    <= psrc1_n;
                out_psrc2    <= psrc2_n;
                out_pdst     <= pdst_n;
                out_old_pdst <= old_pdst_n;
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rename_map.sv
// Bench for rename_map: directed scenarios plus random traffic, checked against a
// sequential-rename reference model (instructions renamed one by one through a map).
module tb_rename_map;

    localparam int AR = 32;
    localparam int IO = 3;
    localparam int AB = 5;
    localparam int PB = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid, in_ready, out_valid, out_ready, flush;
    logic [IO-1:0]   in_en, in_has_dst, fl_get_en, fl_put_en, out_en, out_has_dst, commit_en;
    logic [IO*AB-1:0] in_dst, in_src1, in_src2, commit_arch;
    logic [PB:0]     fl_len;
    logic [IO*PB-1:0] fl_gotten, fl_put, out_psrc1, out_psrc2, out_pdst, out_old_pdst;
    logic [IO*PB-1:0] commit_pdst, commit_old_pdst;

    rename_map dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_en(in_en), .in_has_dst(in_has_dst), .in_dst(in_dst),
        .in_src1(in_src1), .in_src2(in_src2), .fl_len(fl_len),
        .fl_get_en(fl_get_en), .fl_gotten(fl_gotten), .fl_put_en(fl_put_en),
        .fl_put(fl_put), .out_valid(out_valid), .out_ready(out_ready),
        .out_en(out_en), .out_has_dst(out_has_dst), .out_psrc1(out_psrc1),
        .out_psrc2(out_psrc2), .out_pdst(out_pdst), .out_old_pdst(out_old_pdst),
        .commit_en(commit_en), .commit_arch(commit_arch), .commit_pdst(commit_pdst),
        .commit_old_pdst(commit_old_pdst), .flush(flush)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int            spec_m   [AR];
    int            retire_m [AR];
    logic          m_out_valid;
    logic [IO-1:0] m_out_en, m_out_has, m_put_en;
    logic [IO*PB-1:0] m_psrc1, m_psrc2, m_pdst, m_old, m_put;

    function automatic int need_of();
        int n = 0;
        for (int i = 0; i < IO; i++) if (in_en[i] && in_has_dst[i]) n++;
        return n;
    endfunction

    function automatic bit exp_ready();
        return rst && !flush && (!m_out_valid || out_ready) && (need_of() <= int'(fl_len));
    endfunction

    function automatic logic [IO-1:0] exp_get();
        return (in_valid && exp_ready()) ? (in_en & in_has_dst) : '0;
    endfunction

    function automatic logic [IO*PB-1:0] pmask(input logic [IO-1:0] a);
        logic [IO*PB-1:0] m = '0;
        for (int i = 0; i < IO; i++) if (a[i]) m[i*PB +: PB] = '1;
        return m;
    endfunction

    function automatic logic [4*IO*PB+2*IO-1:0] dut_grp();
        return {out_en, out_has_dst, out_psrc1, out_psrc2,
                out_pdst & pmask(m_out_en & m_out_has), out_old_pdst};
    endfunction

    function automatic logic [4*IO*PB+2*IO-1:0] exp_grp();
        return {m_out_en, m_out_has, m_psrc1, m_psrc2,
                m_pdst & pmask(m_out_en & m_out_has), m_old};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < AR; i++) begin
            spec_m[i]   = i;
            retire_m[i] = i;
        end
        m_out_valid = 1'b0;
        m_out_en = '0; m_out_has = '0; m_put_en = '0;
        m_psrc1 = '0; m_psrc2 = '0; m_pdst = '0; m_old = '0; m_put = '0;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; in_en = '0; in_has_dst = '0;
        in_dst = '0; in_src1 = '0; in_src2 = '0; fl_gotten = '0;
        fl_len = 7'd64; out_ready = 1'b1; flush = 1'b0;
        commit_en = '0; commit_arch = '0; commit_pdst = '0; commit_old_pdst = '0;
    endtask

    task automatic set_slot(input int i, input bit en, input bit has, input int dst,
                            input int s1, input int s2, input int tag);
        in_en[i]               = en;
        in_has_dst[i]          = has;
        in_dst[i*AB +: AB]     = AB'(dst);
        in_src1[i*AB +: AB]    = AB'(s1);
        in_src2[i*AB +: AB]    = AB'(s2);
        fl_gotten[i*PB +: PB]  = PB'(tag);
    endtask

    task automatic set_commit(input int i, input bit en, input int arch, input int pdst, input int old);
        commit_en[i]               = en;
        commit_arch[i*AB +: AB]     = AB'(arch);
        commit_pdst[i*PB +: PB]     = PB'(pdst);
        commit_old_pdst[i*PB +: PB] = PB'(old);
    endtask

    // Advance the model by one clock using the current inputs, then step the DUT.
    task automatic tick();
        bit acc;
        int r [AR];
        int map [AR];
        int d, s1, s2;
        acc = in_valid && exp_ready();
        r = retire_m;
        for (int i = 0; i < IO; i++)
            if (commit_en[i]) r[commit_arch[i*AB +: AB]] = int'(commit_pdst[i*PB +: PB]);
        if (acc) begin
            map = spec_m;
            for (int i = 0; i < IO; i++) begin
                d  = int'(in_dst[i*AB +: AB]);
                s1 = int'(in_src1[i*AB +: AB]);
                s2 = int'(in_src2[i*AB +: AB]);
                m_psrc1[i*PB +: PB] = PB'(map[s1]);
                m_psrc2[i*PB +: PB] = PB'(map[s2]);
                m_old[i*PB +: PB]   = PB'(map[d]);
                m_pdst[i*PB +: PB]  = '0;
                if (in_en[i] && in_has_dst[i]) begin
                    m_pdst[i*PB +: PB] = fl_gotten[i*PB +: PB];
                    map[d] = int'(fl_gotten[i*PB +: PB]);
                end
            end
            spec_m      = map;
            m_out_valid = 1'b1;
            m_out_en    = in_en;
            m_out_has   = in_has_dst;
        end else if (flush || out_ready) begin
            m_out_valid = 1'b0;
        end
        if (flush) spec_m = r;
        retire_m = r;
        m_put_en = commit_en;
        m_put    = commit_old_pdst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        model_reset();
        #12;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (fl_put_en !== 3'b000) begin errors++; $display("FAIL reset_put_en got %b exp 000", fl_put_en); end
        checks++;
        if (fl_put !== '0) begin errors++; $display("FAIL reset_put got %h exp 0", fl_put); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        set_slot(0, 1, 1, 1, 2, 3, 32);
        set_slot(1, 1, 1, 4, 1, 1, 33);
        set_slot(2, 1, 1, 1, 4, 0, 34);
        in_valid = 1'b1;
        #1;
        if (fl_get_en !== 3'b111) begin errors++; $display("FAIL basic_get got %b exp 111", fl_get_en); end
        checks++;
        tick();
        in_valid = 1'b0;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        checks++;
        if (dut_grp() !== exp_grp()) begin errors++; $display("FAIL basic_group got %h exp %h", dut_grp(), exp_grp()); end
        checks++;
        if ({out_psrc1[PB +: PB], out_old_pdst[2*PB +: PB]} !== {6'd32, 6'd32}) begin
            errors++; $display("FAIL basic_bypass got %0d/%0d exp 32/32", out_psrc1[PB +: PB], out_old_pdst[2*PB +: PB]);
        end
        checks++;
        tick();
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid); end
        checks++;
    endtask

    task automatic test_fl_backpressure();
        set_slot(0, 1, 1, 6, 1, 4, 35);
        set_slot(1, 1, 1, 7, 6, 1, 36);
        set_slot(2, 1, 1, 8, 7, 6, 37);
        fl_len   = 7'd2;
        in_valid = 1'b1;
        #1;
        if ({in_ready, fl_get_en} !== 4'b0000) begin errors++; $display("FAIL flbp_stall got %b exp 0000", {in_ready, fl_get_en}); end
        checks++;
        tick();
        if (out_valid !== m_out_valid) begin errors++; $display("FAIL flbp_no_out got %b exp %b", out_valid, m_out_valid); end
        checks++;
        fl_len = 7'd3;
        #1;
        if ({in_ready, fl_get_en} !== 4'b1111) begin errors++; $display("FAIL flbp_accept got %b exp 1111", {in_ready, fl_get_en}); end
        checks++;
        tick();
        if (dut_grp() !== exp_grp()) begin errors++; $display("FAIL flbp_group got %h exp %h", dut_grp(), exp_grp()); end
        checks++;
    endtask

    task automatic test_out_stall();
        out_ready = 1'b0;
        fl_len    = 7'd64;
        set_slot(0, 1, 1, 9, 8, 6, 38);
        set_slot(1, 1, 0, 10, 9, 9, 0);
        set_slot(2, 1, 1, 9, 9, 1, 39);
        for (int k = 0; k < 3; k++) begin
            #1;
            if ({in_ready, fl_get_en} !== 4'b0000) begin errors++; $display("FAIL stall_ready%0d got %b exp 0000", k, {in_ready, fl_get_en}); end
            checks++;
            tick();
            if (out_valid !== 1'b1 || dut_grp() !== exp_grp()) begin
                errors++; $display("FAIL stall_hold%0d got %b %h exp 1 %h", k, out_valid, dut_grp(), exp_grp());
            end
            checks++;
        end
        out_ready = 1'b1;
        #1;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", in_ready); end
        checks++;
        tick();
        in_valid = 1'b0;
        if (dut_grp() !== exp_grp()) begin errors++; $display("FAIL stall_next got %h exp %h", dut_grp(), exp_grp()); end
        checks++;
        tick();
    endtask

    task automatic test_commit();
        set_commit(0, 1, 1, 32, 1);
        set_commit(1, 1, 1, 34, 32);
        tick();
        commit_en = '0;
        if (fl_put_en !== 3'b011) begin errors++; $display("FAIL commit_put_en got %b exp 011", fl_put_en); end
        checks++;
        if (fl_put[2*PB-1:0] !== {6'd32, 6'd1}) begin errors++; $display("FAIL commit_put got %h exp %h", fl_put[2*PB-1:0], {6'd32, 6'd1}); end
        checks++;
        flush = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL commit_flush_ready got %b exp 0", in_ready); end
        checks++;
        tick();
        flush = 1'b0;
        if (fl_put_en !== 3'b000) begin errors++; $display("FAIL commit_pulse got %b exp 000", fl_put_en); end
        checks++;
        in_en = '0;
        set_slot(0, 1, 0, 0, 1, 1, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (out_psrc1[0 +: PB] !== 6'd34) begin errors++; $display("FAIL commit_retire got %0d exp 34", out_psrc1[0 +: PB]); end
        checks++;
        tick();
    endtask

    task automatic test_flush_squash();
        in_en = '0;
        set_slot(0, 1, 1, 5, 0, 0, 40);
        in_valid = 1'b1;
        tick();
        if (out_pdst[0 +: PB] !== 6'd40) begin errors++; $display("FAIL squash_rename got %0d exp 40", out_pdst[0 +: PB]); end
        checks++;
        flush = 1'b1;
        #1;
        if ({in_ready, fl_get_en} !== 4'b0000) begin errors++; $display("FAIL squash_no_pop got %b exp 0000", {in_ready, fl_get_en}); end
        checks++;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL squash_valid got %b exp 0", out_valid); end
        checks++;
        set_slot(0, 1, 0, 0, 5, 5, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if ({out_psrc1[0 +: PB], out_psrc2[0 +: PB]} !== {6'd5, 6'd5}) begin
            errors++; $display("FAIL squash_read got %0d/%0d exp 5/5", out_psrc1[0 +: PB], out_psrc2[0 +: PB]);
        end
        checks++;
        tick();
    endtask

    task automatic test_flush_commit();
        set_commit(0, 1, 7, 41, 7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        commit_en = '0;
        if ({fl_put_en, fl_put[0 +: PB]} !== {3'b001, 6'd7}) begin
            errors++; $display("FAIL flcommit_put got %b/%0d exp 001/7", fl_put_en, fl_put[0 +: PB]);
        end
        checks++;
        in_en = '0;
        set_slot(0, 1, 0, 0, 7, 2, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (out_psrc1[0 +: PB] !== 6'd41) begin errors++; $display("FAIL flcommit_read got %0d exp 41", out_psrc1[0 +: PB]); end
        checks++;
        tick();
    endtask

    task automatic test_empty_group();
        in_en = '0;
        in_has_dst = 3'b111;
        fl_len = 7'd0;
        in_valid = 1'b1;
        #1;
        if ({in_ready, fl_get_en} !== 4'b1000) begin errors++; $display("FAIL empty_accept got %b exp 1000", {in_ready, fl_get_en}); end
        checks++;
        tick();
        in_valid = 1'b0;
        fl_len = 7'd64;
        if ({out_valid, out_en} !== 4'b1000) begin errors++; $display("FAIL empty_out got %b exp 1000", {out_valid, out_en}); end
        checks++;
        tick();
    endtask

    task automatic test_random();
        int cnt;
        for (int n = 0; n < 400; n++) begin
            cnt = $urandom_range(0, 3);
            in_en = IO'((1 << cnt) - 1);
            in_has_dst = IO'($urandom);
            for (int i = 0; i < IO; i++)
                set_slot(i, in_en[i], in_has_dst[i], $urandom_range(0, AR-1), $urandom_range(0, AR-1),
                         $urandom_range(0, AR-1), $urandom_range(0, 63));
            fl_len    = ($urandom % 4 == 0) ? 7'($urandom_range(0, 3)) : 7'd64;
            out_ready = ($urandom % 4 != 0);
            in_valid  = ($urandom % 4 != 0);
            flush     = ($urandom % 16 == 0);
            cnt = $urandom_range(0, 3);
            for (int i = 0; i < IO; i++)
                set_commit(i, i < cnt, $urandom_range(0, AR-1), $urandom_range(0, 63), $urandom_range(0, 63));
            #1;
            if ({in_ready, fl_get_en} !== {exp_ready(), exp_get()}) begin
                errors++; $display("FAIL rand_ready%0d got %b exp %b", n, {in_ready, fl_get_en}, {exp_ready(), exp_get()});
            end
            checks++;
            tick();
            if (out_valid !== m_out_valid) begin errors++; $display("FAIL rand_valid%0d got %b exp %b", n, out_valid, m_out_valid); end
            checks++;
            if (m_out_valid && dut_grp() !== exp_grp()) begin
                errors++; $display("FAIL rand_group%0d got %h exp %h", n, dut_grp(), exp_grp());
            end
            checks++;
            if ({fl_put_en, fl_put} !== {m_put_en, m_put}) begin
                errors++; $display("FAIL rand_put%0d got %h exp %h", n, {fl_put_en, fl_put}, {m_put_en, m_put});
            end
            checks++;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_en = '0;
        set_slot(0, 1, 1, 3, 3, 3, 50);
        set_commit(0, 1, 3, 50, 3);
        in_valid = 1'b1;
        tick();
        if ({out_valid, fl_put_en[0]} !== 2'b11) begin errors++; $display("FAIL midrst_pre got %b exp 11", {out_valid, fl_put_en[0]}); end
        checks++;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        if ({out_valid, fl_put_en, in_ready} !== 5'b00000) begin
            errors++; $display("FAIL midrst_clear got %b exp 00000", {out_valid, fl_put_en, in_ready});
        end
        checks++;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        set_slot(0, 1, 0, 0, 3, 1, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if ({out_psrc1[0 +: PB], out_psrc2[0 +: PB]} !== {6'd3, 6'd1}) begin
            errors++; $display("FAIL midrst_identity got %0d/%0d exp 3/1", out_psrc1[0 +: PB], out_psrc2[0 +: PB]);
        end
        checks++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fl_backpressure();
        test_out_stall();
        test_commit();
        test_flush_squash();
        test_flush_commit();
        test_empty_group();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
